// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL responder backed by a byte-lane word array; one response register, full throughput.
// Optional TL_RESPONDER_STALL_EN adds LFSR-driven a_ready stalls to exercise requester back-pressure.
module tl_ul_sram_responder #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SRC_W  = 4,
    parameter int SIZE_W = 2,
    parameter int DEPTH  = 64,
    parameter logic [ADDR_W-1:0] BASE = 'h0002_0000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [2:0]          a_opcode,
    input  logic [2:0]          a_param,
    input  logic [SIZE_W-1:0]   a_size,
    input  logic [SRC_W-1:0]    a_source,
    input  logic [ADDR_W-1:0]   a_address,
    input  logic [DATA_W/8-1:0] a_mask,
    input  logic [DATA_W-1:0]   a_data,
    output logic                d_valid,
    input  logic                d_ready,
    output logic [2:0]          d_opcode,
    output logic [1:0]          d_param,
    output logic [SIZE_W-1:0]   d_size,
    output logic [SRC_W-1:0]    d_source,
    output logic                d_denied,
    output logic [DATA_W-1:0]   d_data
);
    localparam int LANES = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] offset;
    logic [IDX_W-1:0]  idx;
    logic              in_window;
    logic              op_get;
    logic              op_put_full;
    logic              op_put_partial;
    logic              op_bad;
    logic              size_bad;
    logic              misaligned;
    logic              mask_bad;
    logic              denied;
    logic [LANES-1:0]  full_mask;
    logic              accept;
    logic              stall;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] rd_word;

    logic              d_valid_reg;
    logic [2:0]        d_opcode_reg;
    logic [SIZE_W-1:0] d_size_reg;
    logic [SRC_W-1:0]  d_source_reg;
    logic              d_denied_reg;
    logic              data_sel_reg;

    logic              unused_bits;
    assign unused_bits = ^{a_param, offset[1:0]};

    // Window test uses the full offset so nothing past the array aliases back in.
    assign offset    = a_address - BASE;
    assign in_window = (a_address >= BASE) && (offset < ADDR_W'(DEPTH * 4));
    assign idx       = offset[IDX_W+1:2];

    assign op_get         = (a_opcode == 3'd4);
    assign op_put_full    = (a_opcode == 3'd0);
    assign op_put_partial = (a_opcode == 3'd1);
    assign op_bad         = !(op_get || op_put_full || op_put_partial);
    assign size_bad       = (a_size > SIZE_W'(2));

    always_comb begin
        misaligned = 1'b0;
        full_mask  = '0;
        case (a_size)
            SIZE_W'(0): full_mask = LANES'(1) << a_address[1:0];
            SIZE_W'(1): begin
                misaligned = a_address[0];
                full_mask  = LANES'(3) << a_address[1:0];
            end
            SIZE_W'(2): begin
                misaligned = |a_address[1:0];
                full_mask  = '1;
            end
            default: misaligned = 1'b0;
        endcase
    end

    assign mask_bad = op_put_full && (a_mask != full_mask);
    assign denied   = !in_window || size_bad || misaligned || op_bad || mask_bad;

`ifdef TL_RESPONDER_STALL_EN
    logic [7:0] lfsr_reg;
    logic       lfsr_fb;
    assign lfsr_fb = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_reg <= 8'hA5;
        end else begin
            lfsr_reg <= {lfsr_reg[6:0], lfsr_fb};
        end
    end

    assign stall = (lfsr_reg[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    assign a_ready = (!d_valid_reg || d_ready) && !stall;
    // A handshake coinciding with the reset edge must leave no trace in the array.
    assign accept  = a_valid && a_ready && !reset;
    assign wr_en   = accept && !denied && (op_put_full || op_put_partial);
    assign rd_en   = accept && !denied && op_get;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clock) begin
                if (wr_en && a_mask[gi]) begin
                    mem_lane[idx] <= a_data[gi*8 +: 8];
                end
                if (rd_en) begin
                    rd_byte_reg <= mem_lane[idx];
                end
            end

            assign rd_word[gi*8 +: 8] = rd_byte_reg;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            d_valid_reg  <= 1'b0;
            d_opcode_reg <= 3'd0;
            d_size_reg   <= '0;
            d_source_reg <= '0;
            d_denied_reg <= 1'b0;
            data_sel_reg <= 1'b0;
        end else if (accept) begin
            d_valid_reg  <= 1'b1;
            d_opcode_reg <= op_get ? 3'd1 : 3'd0;
            d_size_reg   <= a_size;
            d_source_reg <= a_source;
            d_denied_reg <= denied;
            data_sel_reg <= op_get && !denied;
        end else if (d_valid_reg && d_ready) begin
            d_valid_reg <= 1'b0;
        end
    end

    assign d_valid  = d_valid_reg;
    assign d_opcode = d_opcode_reg;
    assign d_param  = 2'd0;
    assign d_size   = d_size_reg;
    assign d_source = d_source_reg;
    assign d_denied = d_denied_reg;
    // Read lanes carry stale contents after puts and denials; only a legal Get exposes them.
    assign d_data   = data_sel_reg ? rd_word : '0;
endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// Directed bench for tl_ul_sram_responder: vector table plus back-pressure, streaming,
// read-after-write and reset-abort sequences.
module tb_tl_ul_sram_responder;
    localparam logic [31:0] B = 32'h0002_0000;

    logic        clock;
    logic        reset;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [3:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [1:0]  d_size;
    logic [3:0]  d_source;
    logic        d_denied;
    logic [31:0] d_data;

    int tests = 0;
    int fails = 0;

    tl_ul_sram_responder dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source), .d_denied(d_denied), .d_data(d_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [3:0]  src;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic [2:0]  e_op;
        logic        e_den;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] resp_now();
        return 64'({d_valid, d_opcode, d_denied, d_source, d_size, d_param, d_data});
    endfunction

    function automatic logic [63:0] resp_exp(input logic [2:0] op, input logic den,
                                             input logic [3:0] src, input logic [1:0] size,
                                             input logic [31:0] data);
        return 64'({1'b1, op, den, src, size, 2'b00, data});
    endfunction

    task automatic drive_a(input logic [2:0] op, input logic [1:0] size, input logic [3:0] src,
                           input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
        a_opcode  = op;
        a_size    = size;
        a_source  = src;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        a_valid   = 1'b1;
    endtask

    // Called at a negedge with a_valid up; returns at the negedge where a_ready is seen high.
    task automatic wait_ready(input string name);
        int n = 0;
        while (!a_ready && n < 64) begin
            @(negedge clock);
            n++;
        end
        if (!a_ready) begin
            tests++;
            fails++;
            $display("FAIL %s: a_ready timeout got 0 required 1", name);
        end
    endtask

    task automatic run_vec(input int i);
        @(negedge clock);
        drive_a(vecs[i].op, vecs[i].size, vecs[i].src, vecs[i].addr, vecs[i].mask, vecs[i].data);
        wait_ready($sformatf("vec%0d", i));
        @(negedge clock);
        a_valid = 1'b0;
        $display("[TB] vec %0d op=%0d size=%0d addr=%h mask=%h -> d_op=%0d denied=%0b data=%h src=%0d",
                 i, vecs[i].op, vecs[i].size, vecs[i].addr, vecs[i].mask,
                 d_opcode, d_denied, d_data, d_source);
        check($sformatf("vec%0d", i), resp_now(),
              resp_exp(vecs[i].e_op, vecs[i].e_den, vecs[i].src, vecs[i].size, vecs[i].e_data));
    endtask

    initial begin
        int idx;
        int cyc;
        int beats;
        logic prev_acc;
        logic [3:0] prev_src;
        logic [63:0] held;

        vecs[0]  = '{3'd0, 2'd2, 4'd3,  B + 32'h08,  4'hF, 32'hDEADBEEF, 3'd0, 1'b0, 32'h0};
        vecs[1]  = '{3'd4, 2'd2, 4'd5,  B + 32'h08,  4'hF, 32'h0,        3'd1, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{3'd0, 2'd2, 4'd1,  B + 32'h10,  4'hF, 32'h11223344, 3'd0, 1'b0, 32'h0};
        vecs[3]  = '{3'd1, 2'd2, 4'd2,  B + 32'h10,  4'h2, 32'h00005A00, 3'd0, 1'b0, 32'h0};
        vecs[4]  = '{3'd4, 2'd2, 4'd4,  B + 32'h10,  4'hF, 32'h0,        3'd1, 1'b0, 32'h11225A44};
        vecs[5]  = '{3'd4, 2'd2, 4'd6,  B + 32'h100, 4'hF, 32'h0,        3'd1, 1'b1, 32'h0};
        vecs[6]  = '{3'd4, 2'd2, 4'd7,  B + 32'h02,  4'hF, 32'h0,        3'd1, 1'b1, 32'h0};
        vecs[7]  = '{3'd6, 2'd2, 4'd14, B + 32'h08,  4'hF, 32'h0,        3'd0, 1'b1, 32'h0};
        vecs[8]  = '{3'd0, 2'd2, 4'd8,  B + 32'h08,  4'h7, 32'h0,        3'd0, 1'b1, 32'h0};
        vecs[9]  = '{3'd4, 2'd2, 4'd9,  B + 32'h08,  4'hF, 32'h0,        3'd1, 1'b0, 32'hDEADBEEF};
        vecs[10] = '{3'd4, 2'd3, 4'd10, B + 32'h08,  4'hF, 32'h0,        3'd1, 1'b1, 32'h0};
        vecs[11] = '{3'd0, 2'd0, 4'd11, B + 32'h13,  4'h8, 32'hAB000000, 3'd0, 1'b0, 32'h0};
        vecs[12] = '{3'd4, 2'd0, 4'd12, B + 32'h11,  4'h2, 32'h0,        3'd1, 1'b0, 32'hAB225A44};
        vecs[13] = '{3'd4, 2'd2, 4'd13, B - 32'h04,  4'hF, 32'h0,        3'd1, 1'b1, 32'h0};
        vecs[14] = '{3'd0, 2'd2, 4'd15, B + 32'hFC,  4'hF, 32'hCAFEF00D, 3'd0, 1'b0, 32'h0};
        vecs[15] = '{3'd4, 2'd2, 4'd0,  B + 32'hFC,  4'hF, 32'h0,        3'd1, 1'b0, 32'hCAFEF00D};
        vecs[16] = '{3'd0, 2'd1, 4'd1,  B + 32'h12,  4'hC, 32'h77660000, 3'd0, 1'b0, 32'h0};
        vecs[17] = '{3'd4, 2'd1, 4'd2,  B + 32'h10,  4'h3, 32'h0,        3'd1, 1'b0, 32'h77665A44};
        vecs[18] = '{3'd0, 2'd1, 4'd3,  B + 32'h11,  4'h6, 32'h0,        3'd0, 1'b1, 32'h0};
        vecs[19] = '{3'd4, 2'd2, 4'd4,  B + 32'h10,  4'hF, 32'h0,        3'd1, 1'b0, 32'h77665A44};

        reset = 1'b1;
        d_ready = 1'b1;
        a_valid = 1'b0;
        a_param = 3'd0;
        drive_a(3'd4, 2'd2, 4'd0, B, 4'hF, 32'h0);
        a_valid = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset d fields", resp_now(), 64'h0);
        check("reset a_ready", 64'(a_ready), 64'h1);

        for (int i = 0; i < 20; i++) run_vec(i);

        // Back-pressure: hold the Get response for five cycles while a second Get waits.
        @(negedge clock);
        d_ready = 1'b0;
        drive_a(3'd4, 2'd2, 4'd9, B + 32'h08, 4'hF, 32'h0);
        wait_ready("bp accept");
        @(negedge clock);
        drive_a(3'd4, 2'd2, 4'd10, B + 32'h10, 4'hF, 32'h0);
        held = resp_exp(3'd1, 1'b0, 4'd9, 2'd2, 32'hDEADBEEF);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp hold %0d", k), resp_now(), held);
            check($sformatf("bp a_ready %0d", k), 64'(a_ready), 64'h0);
            $display("[TB] bp cycle %0d d_valid=%0b src=%0d a_ready=%0b", k, d_valid, d_source, a_ready);
            @(negedge clock);
        end
        d_ready = 1'b1;
        #1;
        wait_ready("bp release");
        @(negedge clock);
        a_valid = 1'b0;
        check("bp reload", resp_now(), resp_exp(3'd1, 1'b0, 4'd10, 2'd2, 32'h77665A44));
        @(negedge clock);
        check("bp no duplicate", 64'(d_valid), 64'h0);

        // Back-to-back Gets: every accept must surface exactly one cycle later, in order.
        idx = 0; cyc = 0; beats = 0; prev_acc = 1'b0; prev_src = 4'd0;
        while ((idx < 8 || prev_acc) && cyc < 100) begin
            @(negedge clock);
            cyc++;
            if (prev_acc) begin
                check($sformatf("b2b beat %0d", beats), 64'({d_valid, d_source, d_data}),
                      64'({1'b1, prev_src, 32'hDEADBEEF}));
                $display("[TB] b2b beat %0d src=%0d data=%h", beats, d_source, d_data);
                beats++;
            end
            if (idx < 8) begin
                drive_a(3'd4, 2'd2, 4'(idx), B + 32'h08, 4'hF, 32'h0);
                prev_acc = a_ready;
                prev_src = 4'(idx);
                if (a_ready) idx++;
            end else begin
                a_valid = 1'b0;
                prev_acc = 1'b0;
            end
        end
        check("b2b beat count", 64'(beats), 64'd8);
`ifndef TL_RESPONDER_STALL_EN
        check("b2b cycles", 64'(cyc), 64'd9);
`endif

        // Read-after-write on consecutive accepts.
        @(negedge clock);
        drive_a(3'd0, 2'd2, 4'd1, B + 32'h20, 4'hF, 32'h0BADF00D);
        wait_ready("raw put");
        @(negedge clock);
        drive_a(3'd4, 2'd2, 4'd2, B + 32'h20, 4'hF, 32'h0);
        check("raw put ack", resp_now(), resp_exp(3'd0, 1'b0, 4'd1, 2'd2, 32'h0));
        wait_ready("raw get");
        @(negedge clock);
        a_valid = 1'b0;
        check("raw get data", resp_now(), resp_exp(3'd1, 1'b0, 4'd2, 2'd2, 32'h0BADF00D));
        $display("[TB] raw get src=%0d data=%h", d_source, d_data);

        // Reset while a response is pending, with a Put presented on the reset edge.
        @(negedge clock);
        d_ready = 1'b0;
        drive_a(3'd4, 2'd2, 4'd12, B + 32'h08, 4'hF, 32'h0);
        wait_ready("rst get");
        @(negedge clock);
        check("rst pending", 64'(d_valid), 64'h1);
        reset = 1'b1;
        d_ready = 1'b1;
        drive_a(3'd0, 2'd2, 4'd3, B + 32'h08, 4'hF, 32'h55555555);
        @(negedge clock);
        reset = 1'b0;
        a_valid = 1'b0;
        #1;
        check("rst drop", resp_now(), 64'h0);
        check("rst a_ready", 64'(a_ready), 64'h1);
`ifdef TL_RESPONDER_STALL_EN
        begin
            logic [7:0] model;
            model = 8'hA5;
            for (int k = 0; k < 20; k++) begin
                check($sformatf("lfsr ready %0d", k), 64'(a_ready), 64'(model[1:0] != 2'b00));
                model = {model[6:0], model[7] ^ model[5] ^ model[4] ^ model[3]};
                @(negedge clock);
                #1;
            end
        end
`endif
        vecs[0] = '{3'd4, 2'd2, 4'd6, B + 32'h08, 4'hF, 32'h0, 3'd1, 1'b0, 32'hDEADBEEF};
        run_vec(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end
endmodule
